riscv_writeback_arbiter: RTL

- Write-side companion of the 2R1W LUTRAM register file.
- Merges single-cycle execute results and out-of-order long-latency results (load/divide) onto the single write port.
- Drives the register file write address/data from a registered output stage.
- Keeps a 32-entry pending-write scoreboard for hazard detection, and forwards the in-flight write so readers never see the one-cycle LUTRAM write gap.

---
 rtl/riscv_writeback_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/riscv_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_writeback_arbiter
//
// Write-side companion of the 2R1W LUTRAM register file. Single-cycle execute
// results and out-of-order long-latency results (load/divide) share the one
// register-file write port. Execute results have strict priority. Long-latency
// results wait in a small FIFO until the execute stage leaves a bubble.
//
// The write address/data leave through a registered stage (rd0_o/rd0_value_o).
// The register file stores that pair on the following edge. Between those two
// edges the register is readable only through the forwarding flags.
//
// A 32-bit scoreboard marks registers that have a long-latency write
// outstanding. A bit is set when the op issues and cleared when its result
// pops out of the FIFO into the write stage.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   exec_valid_i/rd_i/value_i  execute-stage result (always accepted)
//   issue_valid_i/rd_i         long-latency op issued (sets scoreboard bit)
//   mem_valid_i/rd_i/value_i   long-latency result into the FIFO
//   mem_ready_o                FIFO can accept (from registered count only)
//   ra_i, rb_i                 register-file read addresses being looked up
//   rd0_o, rd0_value_o         register-file write port (rd0_o = 0: no write)
//   ra_pending_o, rb_pending_o read address has an outstanding long-latency write
//   ra_fwd_o, rb_fwd_o         read address matches the in-flight write
// -----------------------------------------------------------------------------
module riscv_writeback_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int FIFO_AW    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exec_valid_i,
  input  logic [4:0]  exec_rd_i,
  input  logic [31:0] exec_value_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_value_i,
  output logic        mem_ready_o,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [4:0]  rd0_o,
  output logic [31:0] rd0_value_o,
  output logic        ra_pending_o,
  output logic        rb_pending_o,
  output logic        ra_fwd_o,
  output logic        rb_fwd_o
);

  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  // One-hot mask of a register index for scoreboard set/clear.
  function automatic logic [31:0] reg_mask(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

  // FIFO storage (data only, never reset: validity is tracked by count_q)
  logic [4:0]  fifo_rd_q  [FIFO_DEPTH];
  logic [31:0] fifo_val_q [FIFO_DEPTH];

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q,  count_d;
  logic [31:0]        sb_q,     sb_d;
  logic [4:0]         rd0_q,    rd0_d;
  logic [31:0]        rd0_value_q, rd0_value_d;

  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_val;

  // Ready depends only on the registered count so a source can never form a
  // combinational loop through mem_valid_i.
  assign mem_ready_o = (count_q != CNT_FULL);

  assign head_rd  = fifo_rd_q[rd_ptr_q];
  assign head_val = fifo_val_q[rd_ptr_q];

  // Input stage: push/pop decisions and next-state computation
  always_comb begin
    push        = mem_valid_i & mem_ready_o;
    pop         = ~exec_valid_i & (count_q != '0);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd0_d       = 5'd0;
    rd0_value_d = rd0_value_q;
    sb_d        = sb_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (exec_valid_i) begin
      rd0_d       = exec_rd_i;
      rd0_value_d = exec_value_i;
    end else if (pop) begin
      rd0_d       = head_rd;
      rd0_value_d = head_val;
    end

    // Clear before set so a same-cycle re-issue of the popping register
    // keeps its bit: the new op is still outstanding.
    if (pop) begin
      sb_d = sb_d & ~reg_mask(head_rd);
    end
    if (issue_valid_i) begin
      sb_d = sb_d | reg_mask(issue_rd_i);
    end
    sb_d[0] = 1'b0;
  end

  // FIFO write
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]  <= mem_rd_i;
      fifo_val_q[wr_ptr_q] <= mem_value_i;
    end
  end

  // Registered write stage and control state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sb_q        <= '0;
      rd0_q       <= '0;
      rd0_value_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sb_q        <= sb_d;
      rd0_q       <= rd0_d;
      rd0_value_q <= rd0_value_d;
    end
  end

  // Output stage: lookups from registered state and read addresses
  assign rd0_o        = rd0_q;
  assign rd0_value_o  = rd0_value_q;
  assign ra_pending_o = sb_q[ra_i];
  assign rb_pending_o = sb_q[rb_i];
  // The in-flight write is not yet in the LUTRAM; its scoreboard bit may
  // already be clear, so readers must take rd0_value_o instead.
  assign ra_fwd_o     = (rd0_q != 5'd0) && (rd0_q == ra_i);
  assign rb_fwd_o     = (rd0_q != 5'd0) && (rd0_q == rb_i);

endmodule
